div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port signed_div_i, input, 1 bit: 1 for DIV (signed), 0 for DIVU; driven from the execute-stage decode of alucontrolE.
REQ-004 SHALL have port opdata1_i, input, 32 bits: dividend (execute-stage rs value, after forwarding).
REQ-005 SHALL have port opdata2_i, input, 32 bits: divisor (execute-stage rt value, after forwarding).
REQ-006 SHALL have port start_i, input, 1 bit: request, equal to hazard unit div_start.
REQ-007 SHALL have port annul_i, input, 1 bit: abort the current operation (exception or flush).
REQ-008 SHALL have port result_o, output, 64 bits: {remainder[63:32], quotient[31:0]}, i.e. {hi, lo}.
REQ-009 SHALL have port ready_o, output, 1 bit: result valid, fed back as hazard unit div_ready.

Function
REQ-010 SHALL implement a 4-state FSM with states FREE, BY_ZERO, ON, END.
REQ-011 FREE: if start_i=1 and annul_i=0, SHALL latch signed_div_i and both operands, then go to BY_ZERO when opdata2_i=0, otherwise go to ON; in all other cases SHALL stay in FREE.
REQ-012 On the FREE->ON transition, in signed mode, SHALL latch abs(opdata1_i) and abs(opdata2_i), plus both sign bits.
REQ-013 ON SHALL run 32 restoring-division iterations, one per clock, with a 6-bit counter (0..31) and a 65-bit working register {partial remainder, dividend shift}.
REQ-014 Each iteration: trial = partial remainder minus divisor (33-bit). If trial is non-negative, remainder = trial and shift in quotient bit 1; otherwise keep the remainder and shift in 0.
REQ-015 After iteration 31, SHALL apply the signed fixup and go to END.
REQ-016 Signed fixup: negate the quotient when the dividend and divisor signs differ; give the remainder the dividend's sign (two's complement, mod 2^32).
REQ-017 0x80000000 / 0xFFFFFFFF signed SHALL produce quotient 0x80000000 and remainder 0, with no trap.
REQ-018 BY_ZERO SHALL set result 64'h0 and go to END on the next edge.
REQ-019 END SHALL register result_o and drive ready_o=1.
REQ-020 END SHALL stay in END, holding result_o and ready_o, while start_i=1.
REQ-021 END SHALL go to FREE with ready_o=0 and result_o=0 when start_i=0.
REQ-022 ready_o and result_o SHALL be registered outputs, and SHALL be 0 in every state except END.
REQ-023 Latency: the first edge with start_i sampled high is edge k. ready_o SHALL rise after edge k+33 (ON path) or after edge k+2 (BY_ZERO path).
REQ-024 Changes on opdata1_i, opdata2_i or signed_div_i after the start edge SHALL be ignored.
REQ-025 annul_i=1 in any state SHALL force FREE on the next edge, with ready_o=0 and result_o=0; annul_i SHALL take priority over start_i.
REQ-026 start_i falling while in BY_ZERO or ON SHALL abort the operation and go to FREE.

Reset
REQ-027 rst=1 SHALL asynchronously force state FREE, counter 0, working register 0, result_o 0 and ready_o 0, including in the middle of an operation.
REQ-028 After rst deasserts, the first start_i SHALL be accepted normally.

Structure
REQ-029 The shared package SHALL hold the state encodings (DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END), DIV_ITER=32, ZERO_WORD/ZERO_DWORD, and the existing EXE_DIV_OP/EXE_DIVU_OP codes.
REQ-030 The block SHALL be a single module with no sub-modules; the iteration datapath is inline.
REQ-031 The block SHALL instantiate no memories and SHALL have no combinational path from any input to any output.

Verification
REQ-032 Unsigned 100/7, start held: result_o=0x00000002_0000000E, ready_o rises 34 edges after start. Drop start: FREE, ready_o=0 next cycle.
REQ-033 Signed 0xFFFFFFF9/0x00000002 (-7/2): result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3).
REQ-034 Divide by zero, 0x12345678/0: result_o=64'h0 and ready_o high after edge k+2.
REQ-035 Signed 0x80000000/0xFFFFFFFF: result_o=0x00000000_80000000; unsigned 0xFFFFFFFF/1: result_o=0x00000000_FFFFFFFF.
REQ-036 annul_i pulse at iteration 10: FREE next edge, ready_o stays 0. Immediate new 9/3: result_o=0x00000000_00000003.
REQ-037 rst pulse mid-ON and also mid-END: all outputs 0 immediately (asynchronous). A subsequent 100/7 SHALL give the REQ-032 result and timing.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle integer divider: FSM states,
// iteration count, zero constants and the execute-stage divide opcodes.
package div_pkg;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_t;

   localparam int          DIV_ITER   = 32;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
   localparam logic [63:0] ZERO_DWORD = 64'h0000_0000_0000_0000;

   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   // Magnitude of a two's-complement word; 0x80000000 maps to itself,
   // which is the correct unsigned magnitude.
   function automatic logic [31:0] abs_word(input logic [31:0] w);
      return w[31] ? (~w + 32'd1) : w;
   endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_if;
   import div_pkg::*;

   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;

   modport master (
      output signed_div, opdata1, opdata2, start, annul,
      input  result, ready
   );

   modport slave (
      input  signed_div, opdata1, opdata2, start, annul,
      output result, ready
   );

endinterface

// File: rtl/div.sv
// Restoring radix-2 divider: 32 iterations, signed fixup, result held in END
// while start stays high.
module div
   import div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   div_state_t  state;
   logic [5:0]  cnt;
   logic [64:0] work;
   logic [31:0] divisor;
   logic        signed_op;
   logic        sign1;
   logic        sign2;

   logic [33:0] rem_shift;
   logic [33:0] trial;
   logic        take;
   logic [32:0] next_rem;
   logic [31:0] next_quo;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // One restoring step: shift the next dividend bit into the partial
   // remainder and keep the subtraction only when it does not go negative.
   always_comb begin
      rem_shift = {work[64:32], work[31]};
      trial     = rem_shift - {2'b00, divisor};
      take      = ~trial[33];
      next_rem  = take ? trial[32:0] : rem_shift[32:0];
      next_quo  = {work[30:0], take};
      quo_fix   = (signed_op && (sign1 ^ sign2)) ? (~next_quo + 32'd1) : next_quo;
      rem_fix   = (signed_op && sign1) ? (~next_rem[31:0] + 32'd1) : next_rem[31:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= DIV_FREE;
         cnt       <= 6'd0;
         work      <= 65'd0;
         divisor   <= ZERO_WORD;
         signed_op <= 1'b0;
         sign1     <= 1'b0;
         sign2     <= 1'b0;
         result_o  <= ZERO_DWORD;
         ready_o   <= 1'b0;
      end else if (annul_i) begin
         state    <= DIV_FREE;
         cnt      <= 6'd0;
         result_o <= ZERO_DWORD;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            DIV_FREE: begin
               result_o <= ZERO_DWORD;
               ready_o  <= 1'b0;
               if (start_i) begin
                  signed_op <= signed_div_i;
                  sign1     <= opdata1_i[31];
                  sign2     <= opdata2_i[31];
                  cnt       <= 6'd0;
                  work      <= {33'd0, signed_div_i ? abs_word(opdata1_i) : opdata1_i};
                  divisor   <= signed_div_i ? abs_word(opdata2_i) : opdata2_i;
                  state     <= (opdata2_i == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
               end
            end
            DIV_BY_ZERO: begin
               if (!start_i) begin
                  state <= DIV_FREE;
               end else begin
                  work  <= 65'd0;
                  state <= DIV_END;
               end
            end
            // The last iteration writes the sign-corrected {rem, quo} so END
            // only has to copy it out.
            DIV_ON: begin
               if (!start_i) begin
                  state <= DIV_FREE;
                  cnt   <= 6'd0;
               end else if (cnt == 6'(DIV_ITER - 1)) begin
                  work  <= {1'b0, rem_fix, quo_fix};
                  cnt   <= 6'd0;
                  state <= DIV_END;
               end else begin
                  work <= {next_rem, next_quo};
                  cnt  <= cnt + 6'd1;
               end
            end
            DIV_END: begin
               if (start_i) begin
                  result_o <= work[63:0];
                  ready_o  <= 1'b1;
               end else begin
                  result_o <= ZERO_DWORD;
                  ready_o  <= 1'b0;
                  state    <= DIV_FREE;
               end
            end
            default: state <= DIV_FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed vector table, multi-cycle corner
// sequences and randomized operations checked against an arithmetic model.
module tb_div;
   import div_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   div_if bus();

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (bus.signed_div),
      .opdata1_i    (bus.opdata1),
      .opdata2_i    (bus.opdata2),
      .start_i      (bus.start),
      .annul_i      (bus.annul),
      .result_o     (bus.result),
      .ready_o      (bus.ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[11];

   // Reference: plain integer division, widened to 64 bits so that
   // 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
   function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [31:0] uq, ur;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Counts edges from the next rising edge until ready; operands are
   // scrambled right after the start edge, which the DUT must ignore.
   task automatic waitReady(output logic [63:0] res, output int lat);
      lat = 0;
      res = 64'd0;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk);
         #1;
         if (e == 1) begin
            bus.signed_div = 1'($urandom);
            bus.opdata1    = $urandom;
            bus.opdata2    = $urandom;
         end
         if (bus.ready) begin
            lat = e;
            res = bus.result;
            break;
         end
      end
   endtask

   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] res, output int lat);
      @(negedge clk);
      bus.signed_div = sgn;
      bus.opdata1    = a;
      bus.opdata2    = b;
      bus.start      = 1'b1;
      waitReady(res, lat);
   endtask

   task automatic finishOp(input string name);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({name, "_drop_ready"}, 64'(bus.ready), 64'd0);
      checkOutput({name, "_drop_result"}, bus.result, 64'd0);
   endtask

   task automatic runChecked(input string name, input logic sgn, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp);
      logic [63:0] res;
      int          lat;
      applyStimulus(sgn, a, b, res, lat);
      checkOutput({name, "_result"}, res, exp);
      checkOutput({name, "_latency"}, 64'(lat), (b == 32'd0) ? 64'd3 : 64'd34);
      finishOp(name);
   endtask

   initial begin
      logic [63:0] res;
      int          lat;
      logic        sgn;
      logic [31:0] a, b;

      bus.signed_div = 1'b0;
      bus.opdata1    = 32'd0;
      bus.opdata2    = 32'd0;
      bus.start      = 1'b0;
      bus.annul      = 1'b0;
      rst            = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_ready", 64'(bus.ready), 64'd0);
      checkOutput("reset_result", bus.result, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD};
      vecs[2]  = '{1'b0, 32'h12345678,   32'h00000000,   64'h00000000_00000000};
      vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
      vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF};
      vecs[5]  = '{1'b0, 32'd9,          32'd3,          64'h00000000_00000003};
      vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
      vecs[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000};
      vecs[8]  = '{1'b0, 32'd5,          32'd10,         64'h00000005_00000000};
      vecs[9]  = '{1'b1, 32'h00000000,   32'h00000000,   64'h00000000_00000000};
      vecs[10] = '{1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD,   64'hFFFFFFFE_00000002};

      for (int i = 0; i < 11; i++)
         runChecked($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

      // END must hold its result while start stays high.
      applyStimulus(1'b0, 32'd100, 32'd7, res, lat);
      checkOutput("hold_first", res, 64'h00000002_0000000E);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("hold_ready%0d", i), 64'(bus.ready), 64'd1);
         checkOutput($sformatf("hold_result%0d", i), bus.result, 64'h00000002_0000000E);
      end
      finishOp("hold");

      // Annul around iteration 10, then an immediate new 9/3 with start still high.
      @(negedge clk);
      bus.signed_div = 1'b0;
      bus.opdata1    = 32'd100;
      bus.opdata2    = 32'd7;
      bus.start      = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      bus.annul = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("annul_ready", 64'(bus.ready), 64'd0);
      checkOutput("annul_result", bus.result, 64'd0);
      @(negedge clk);
      bus.annul   = 1'b0;
      bus.opdata1 = 32'd9;
      bus.opdata2 = 32'd3;
      waitReady(res, lat);
      checkOutput("annul_new_result", res, 64'h00000000_00000003);
      checkOutput("annul_new_latency", 64'(lat), 64'd34);
      finishOp("annul_new");

      // Dropping start mid-ON aborts; a restarted op takes the full latency.
      @(negedge clk);
      bus.opdata1 = 32'd100;
      bus.opdata2 = 32'd7;
      bus.start   = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort_ready", 64'(bus.ready), 64'd0);
      @(negedge clk);
      bus.signed_div = 1'b0;
      bus.opdata1    = 32'd9;
      bus.opdata2    = 32'd3;
      bus.start      = 1'b1;
      waitReady(res, lat);
      checkOutput("abort_new_result", res, 64'h00000000_00000003);
      checkOutput("abort_new_latency", 64'(lat), 64'd34);
      finishOp("abort_new");

      // Asynchronous reset in the middle of ON.
      @(negedge clk);
      bus.signed_div = 1'b0;
      bus.opdata1    = 32'd100;
      bus.opdata2    = 32'd7;
      bus.start      = 1'b1;
      repeat (15) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_on_ready", 64'(bus.ready), 64'd0);
      checkOutput("rst_on_result", bus.result, 64'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      runChecked("after_rst_on", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

      // Asynchronous reset while END is presenting a result.
      applyStimulus(1'b0, 32'd100, 32'd7, res, lat);
      checkOutput("pre_rst_end_result", res, 64'h00000002_0000000E);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_end_ready", 64'(bus.ready), 64'd0);
      checkOutput("rst_end_result", bus.result, 64'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      runChecked("after_rst_end", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom);
         a   = $urandom;
         case ($urandom_range(0, 3))
            0:       b = $urandom_range(1, 15);
            1:       b = (i % 4 == 0) ? 32'd0 : $urandom_range(1, 255);
            2:       b = 32'hFFFFFFFF - $urandom_range(0, 15);
            default: b = $urandom;
         endcase
         runChecked($sformatf("rand%0d", i), sgn, a, b, refDiv(sgn, a, b));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
